bcd_seq_converter: RTL
======================

// Module: bcd_seq_converter
// PURPOSE
//  Sequential binary-to-BCD converter with 7-segment outputs. Converts a N-bit unsigned value
//  using shift-and-add-3 (double dabble), one bit per clock, so no divide/modulo logic is built.
//  Start/busy/done handshake; optional leading-zero blanking; overflow flag when DIGITS is too
//  small. Sits between datapath counters/ALUs and the board's 7-segment displays.
// PARAMETERS
//  N        10  width of binary input, unsigned, N>=1
//  DIGITS   4   number of decimal digits / displays driven, DIGITS>=1
//  BLANK_LZ 1   1: blank leading zero digits (digit 0 always shown); 0: show all digits
// PORTS
//  clk      in   1          rising-edge clock
//  rst_n    in   1          asynchronous active-low reset
//  start    in   1          request conversion of bin_in; sampled only in IDLE
//  bin_in   in   N          binary value, captured on accepted start
//  busy     out  1          1 while converting (SHIFT state)
//  done     out  1          one-cycle pulse: results valid and updated this cycle
//  ovf      out  1          last result >= 10**DIGITS; held with the result
//  bcd_out  out  4*DIGITS   digit k at [4k+3:4k], k=0 is units; held until next done
//  seg_out  out  7*DIGITS   digit k at [7k+6:7k], order {a..g}, active-low; held until next done
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE, busy=0, done=0, ovf=0, bcd_out=0, seg_out all SEG_BLANK,
//    scratch and bit counter cleared. Reset mid-conversion aborts; no done; outputs as above.
//  - Internal digits ID = max(DIGITS, ceil(N*log10 2)) = max(DIGITS,(N*301+999)/1000).
//  - FSM IDLE: start=1 -> latch bin_in into shift reg, clear ID*4-bit BCD scratch, cnt=0 -> SHIFT.
//    SHIFT: each cycle, every scratch digit >=5 gets +3, then {scratch,shreg} shifted left by 1;
//    cnt++; after the N-th shift -> DONE. DONE: register outputs, done=1 for this cycle -> IDLE.
//  - Latency: start accepted at edge 0 -> busy high edges 1..N -> done high in cycle after edge N+1
//    (done asserted N+1 cycles after start sampled). Throughput: one result per N+2 cycles.
//  - start while busy or in DONE: ignored, not queued. start in IDLE in cycle after done: accepted.
//  - bin_in changes after capture do not affect current conversion.
//  - ovf=1 iff any scratch digit with index >= DIGITS is nonzero; bcd_out then holds the low
//    DIGITS digits (value mod 10**DIGITS). ovf=0 always when ID==DIGITS.
//  - Blanking (BLANK_LZ=1): digit k>0 blanked (SEG_BLANK) if it and all higher digits within
//    DIGITS are zero; digit 0 never blanked; on ovf no blanking applied. bcd_out never blanked.
//  - seg_out, bcd_out, ovf all update on the same edge; no glitching between done pulses.
// STRUCTURE
//  - Package bcd_pkg: SEG_BLANK=7'b1111111, BCD digit typedef (4 bits), state enum
//    {IDLE,SHIFT,DONE}, function digits_needed(N).
//  - Sub-module: reuse existing decoder_7_seg (4-bit in, 7-bit active-low out), one instance per
//    digit via generate; blanking mux after decoder, before output register.
//  - Counter width $clog2(N+1). No multipliers/dividers in synthesised logic.
// TESTING
//  1 N=10,D=4: bin_in=1023, start 1 cycle -> done exactly N+1 cycles later; bcd_out=16'h1023,
//    ovf=0, segs show 1,0,2,3.
//  2 bin_in=0, BLANK_LZ=1 -> bcd_out=0, digit0 shows '0' (7'b0000001), digits1..3 = SEG_BLANK;
//    BLANK_LZ=0 -> all four show '0'.
//  3 bin_in=7, then start held high and bin_in=999 during busy -> single done, bcd_out=16'h0007;
//    start in cycle after done with 999 -> next done gives 16'h0999, digit3 blank.
//  4 N=10,D=3, bin_in=1000 -> ovf=1, bcd_out=12'h000, all three digits shown (no blanking).
//  5 rst_n low at shift 5 of a conversion -> no done, busy=0, outputs reset values; new start
//    after release with 512 -> bcd_out=16'h0512 after N+1 cycles.
//  6 Exhaustive N=10: all 0..1023 back-to-back vs. reference model (/ and %); ovf=0 throughout.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter
// and its 7-segment decoders.
package bcd_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  // Decimal digits needed to hold any N-bit unsigned value: ceil(n*log10(2)).
  // Evaluated only at elaboration, so the multiply builds no hardware.
  function automatic int digits_needed(input int n);
    return (n * 301 + 999) / 1000;
  endfunction

endpackage

// File: rtl/decoder_7_seg.sv
// BCD digit to active-low 7-segment pattern, bit order {a,b,c,d,e,f,g}.
// Non-decimal codes show a blank display.
module decoder_7_seg
  import bcd_pkg::*;
(
  input  bcd_digit_t digit,
  output logic [6:0] seg
);

  always_comb begin
    case (digit)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0000100;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_seq_converter.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock)
// with registered BCD, overflow and active-low 7-segment outputs.
module bcd_seq_converter
  import bcd_pkg::*;
#(
  parameter int N        = 10,
  parameter int DIGITS   = 4,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [N-1:0]          bin_in,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [7*DIGITS-1:0]   seg_out
);

  localparam int NEED  = digits_needed(N);
  localparam int ID    = (DIGITS > NEED) ? DIGITS : NEED;
  localparam int CNT_W = $clog2(N + 1);

  state_t                state, state_next;
  logic [N-1:0]          shreg;
  logic [4*ID-1:0]       scratch, scratch_adj;
  logic [CNT_W-1:0]      cnt;
  logic                  last_shift;
  logic                  ovf_next;
  logic                  lead_zero;
  logic [7*DIGITS-1:0]   seg_raw, seg_next;

  assign busy       = (state == SHIFT);
  assign last_shift = (cnt == CNT_W'(N - 1));

  // NOTE: every variable driven in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    scratch_adj = scratch;
    for (int k = 0; k < ID; k++) begin
      if (scratch[4*k +: 4] >= 4'd5) scratch_adj[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last_shift) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Digits beyond the displayed ones exist only when DIGITS is too small for N.
  if (ID > DIGITS) begin : g_ovf
    assign ovf_next = |scratch[4*ID-1:4*DIGITS];
  end else begin : g_no_ovf
    assign ovf_next = 1'b0;
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_dec
    decoder_7_seg u_dec (
      .digit (scratch[4*k +: 4]),
      .seg   (seg_raw[7*k +: 7])
    );
  end

  // Walk down from the top digit; a digit stays blank while everything above it is zero.
  always_comb begin
    seg_next  = seg_raw;
    lead_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      lead_zero = lead_zero && (scratch[4*k +: 4] == 4'd0);
      if ((BLANK_LZ != 0) && !ovf_next && lead_zero) seg_next[7*k +: 7] = SEG_BLANK;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shreg   <= '0;
      scratch <= '0;
      cnt     <= '0;
      done    <= 1'b0;
      ovf     <= 1'b0;
      bcd_out <= '0;
      seg_out <= {DIGITS{SEG_BLANK}};
    end else begin
      state <= state_next;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) shreg <= bin_in;
          scratch <= '0;
          cnt     <= '0;
        end
        SHIFT: begin
          {scratch, shreg} <= {scratch_adj, shreg} << 1;
          cnt              <= cnt + 1'b1;
        end
        DONE: begin
          done    <= 1'b1;
          ovf     <= ovf_next;
          bcd_out <= scratch[4*DIGITS-1:0];
          seg_out <= seg_next;
        end
        default: ;
      endcase
    end
  end

endmodule
